// File: rtl/mem_byte_writer_if.sv
// RAM-side port bundle for mem_byte_writer: write strobe, address, write data
// and the synchronous read data returned by the byte RAM.
interface mem_byte_writer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) ();
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] DI;
  logic [DATA_WIDTH-1:0] DO;

  modport master (output write_enable, output addr, output DI, input DO);
  modport slave  (input write_enable, input addr, input DI, output DO);
endinterface

// File: rtl/mem_byte_writer.sv
// Button-driven byte writer: debounced press writes sw at an auto-incrementing
// address and verifies it by readback; a second button zero-fills the RAM.
module mem_byte_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DB_CYCLES  = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sw,
  input  logic                  btn_write,
  input  logic                  btn_clear,
  mem_byte_writer_if.master     ram,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] last_data,
  output logic                  err
);

  localparam int             CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CHECK = 3'd3,
    CLEAR = 3'd4
  } state_t;

  // bit 0 = write button, bit 1 = clear button
  logic [1:0]            sync1_r, sync2_r, stable_r, press_r;
  logic [CNT_W-1:0]      cnt_r [2];

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] ptr_r, ptr_s;
  logic [DATA_WIDTH-1:0] di_r, di_s;
  logic [DATA_WIDTH-1:0] last_r, last_s;
  logic                  err_r, err_s;
  logic                  we_r, we_s;
  logic                  busy_r, busy_s;

  // Button synchronisers and debouncers; a press pulse fires when the stable level rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r  <= 2'b00;
      sync2_r  <= 2'b00;
      stable_r <= 2'b00;
      press_r  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_r <= {btn_clear, btn_write};
      sync2_r <= sync1_r;
      press_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end else if (cnt_r[i] == CNT_MAX) begin
          cnt_r[i]    <= {CNT_W{1'b0}};
          stable_r[i] <= sync2_r[i];
          press_r[i]  <= sync2_r[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Next-state, pointer, data and status logic for the write/verify/clear sequencer.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    di_s    = di_r;
    last_s  = last_r;
    err_s   = err_r;
    case (state_r)
      IDLE: begin
        if (press_r[1]) begin
          state_s = CLEAR;
          ptr_s   = {ADDR_WIDTH{1'b0}};
          di_s    = {DATA_WIDTH{1'b0}};
        end else if (press_r[0]) begin
          state_s = WRITE;
          di_s    = sw;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        last_s  = di_r;
        state_s = READ;
      end
      READ: begin
        state_s = CHECK;
      end
      CHECK: begin
        if (ram.DO != di_r) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
        ptr_s   = ptr_r + ADDR_WIDTH'(1);
        state_s = IDLE;
      end
      CLEAR: begin
        ptr_s = ptr_r + ADDR_WIDTH'(1);
        if (ptr_r == {ADDR_WIDTH{1'b1}}) begin
          state_s = IDLE;
        end else begin
          state_s = CLEAR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    we_s   = (state_s == WRITE) || (state_s == CLEAR);
    busy_s = (state_s != IDLE);
  end

  // Sequencer state and registered RAM/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= {ADDR_WIDTH{1'b0}};
      di_r    <= {DATA_WIDTH{1'b0}};
      last_r  <= {DATA_WIDTH{1'b0}};
      err_r   <= 1'b0;
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      di_r    <= di_s;
      last_r  <= last_s;
      err_r   <= err_s;
      we_r    <= we_s;
      busy_r  <= busy_s;
    end
  end

  assign ram.write_enable = we_r;
  assign ram.addr         = ptr_r;
  assign ram.DI           = di_r;
  assign busy             = busy_r;
  assign last_data        = last_r;
  assign err              = err_r;

endmodule
